page_reg_bank: RTL and testbench

Eight-entry by eight-bit page register bank with a sequential write pointer, a registered read port and a serial scan chain. It implements the page-register storage that the bus-page decode stage instantiates per byte lane. Data bytes are loaded in order and read back by page select. The scan chain lets test logic load and unload every stored bit without using the functional ports.

---
 rtl/page_reg_bank_if.sv | 43 ++++
 rtl/page_reg_bank.sv | 106 ++++++++++
 tb/tb_page_reg_bank.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/page_reg_bank_if.sv
// Bus bundle for page_reg_bank: write port, read port, status flags and scan pins.
// par_err exists only when PAGE_REG_PARITY_EN is defined.
interface page_reg_bank_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) ();
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] data_in;
    logic             en_in;
    logic             wr_clr;
    logic             rd_en;
    logic [AW-1:0]    rd_sel;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic [DEPTH-1:0] valid;
    logic             full;
    logic             ovf;
    logic             tc;
    logic             td;
    logic             tq;
`ifdef PAGE_REG_PARITY_EN
    logic             par_err;

    modport master (
        output data_in, en_in, wr_clr, rd_en, rd_sel, tc, td,
        input  data_out, rd_valid, valid, full, ovf, tq, par_err
    );
    modport slave (
        input  data_in, en_in, wr_clr, rd_en, rd_sel, tc, td,
        output data_out, rd_valid, valid, full, ovf, tq, par_err
    );
`else
    modport master (
        output data_in, en_in, wr_clr, rd_en, rd_sel, tc, td,
        input  data_out, rd_valid, valid, full, ovf, tq
    );
    modport slave (
        input  data_in, en_in, wr_clr, rd_en, rd_sel, tc, td,
        output data_out, rd_valid, valid, full, ovf, tq
    );
`endif
endinterface

// File: rtl/page_reg_bank.sv
// Page register bank: sequential-pointer writes, registered reads and a full-array scan chain.
// Optional even parity per entry with read-time checking when PAGE_REG_PARITY_EN is defined.
module page_reg_bank #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input logic           clk,
    input logic           reset,
    page_reg_bank_if.slave bus
);
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LAST = DEPTH - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    wr_ptr;
    logic             ovf_q;
    logic [WIDTH-1:0] data_out_q;
    logic             rd_valid_q;
`ifdef PAGE_REG_PARITY_EN
    logic [DEPTH-1:0] par;
    logic             par_err_q;
`endif

    logic [DEPTH-1:0] cin_c;
    logic [AW-1:0]    wr_idx_c;
    logic [DEPTH-1:0] valid_base_c;
    logic             full_c;

    // Scan carry-in per entry and the effective write slot once a same-cycle clear is applied
    always_comb begin
        cin_c        = '0;
        cin_c[0]     = bus.td;
        for (int i = 1; i < int'(DEPTH); i++) begin
            cin_c[i] = mem[i-1][WIDTH-1];
        end
        wr_idx_c     = bus.wr_clr ? '0 : wr_ptr;
        valid_base_c = bus.wr_clr ? '0 : valid_q;
        full_c       = &valid_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            valid_q    <= '0;
            wr_ptr     <= '0;
            ovf_q      <= 1'b0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
`ifdef PAGE_REG_PARITY_EN
            par        <= '0;
            par_err_q  <= 1'b0;
`endif
        end else if (bus.tc) begin
            // Whole array shifts as one chain; functional strobes are ignored
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= WIDTH'({mem[i], cin_c[i]});
`ifdef PAGE_REG_PARITY_EN
                par[i] <= ^(WIDTH'({mem[i], cin_c[i]}));
`endif
            end
            rd_valid_q <= 1'b0;
`ifdef PAGE_REG_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            rd_valid_q <= bus.rd_en & valid_q[bus.rd_sel];
            if (bus.rd_en) begin
                data_out_q <= mem[bus.rd_sel];
            end
`ifdef PAGE_REG_PARITY_EN
            par_err_q <= bus.rd_en & ((^mem[bus.rd_sel]) != par[bus.rd_sel]);
`endif
            if (bus.wr_clr) begin
                valid_q <= '0;
                wr_ptr  <= '0;
                ovf_q   <= 1'b0;
            end
            // A write merged with a clear lands in entry 0 and cannot overflow
            if (bus.en_in) begin
                mem[wr_idx_c] <= bus.data_in;
                valid_q       <= valid_base_c | (DEPTH'(1) << wr_idx_c);
                wr_ptr        <= (wr_idx_c == AW'(LAST)) ? '0 : wr_idx_c + AW'(1);
`ifdef PAGE_REG_PARITY_EN
                par[wr_idx_c] <= ^bus.data_in;
`endif
                if (!bus.wr_clr && full_c) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.valid    = valid_q;
    assign bus.full     = full_c;
    assign bus.ovf      = ovf_q;
    assign bus.tq       = mem[DEPTH-1][WIDTH-1];
`ifdef PAGE_REG_PARITY_EN
    assign bus.par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_page_reg_bank.sv
// Scoreboard bench for page_reg_bank: a bit-vector model of the array predicts every cycle's outputs.
// Parity checks are exercised when PAGE_REG_PARITY_EN is defined.
module tb_page_reg_bank;
    localparam int W = 8;
    localparam int D = 8;
    localparam int NB = W * D;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    page_reg_bank_if #(.WIDTH(W), .DEPTH(D)) bus ();

    page_reg_bank #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         rdv;
        logic [D-1:0] valid;
        logic         full;
        logic         ovf;
        logic         tq;
        logic         perr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: the array is one NB-bit vector, entry i at bits [i*W +: W]
    bit [NB-1:0] chain;
    bit [D-1:0]  vmask;
    int          ptr;
    bit          movf;
    bit [W-1:0]  last_data;
    bit [D-1:0]  mpar;
    bit          rdv_m;
    bit          perr_m;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endfunction

    function automatic void model_reset();
        chain = '0; vmask = '0; ptr = 0; movf = 0;
        last_data = '0; mpar = '0; rdv_m = 0; perr_m = 0;
    endfunction

    // Applies the inputs sampled at this edge to the model and queues the expected outputs
    task automatic model_apply();
        exp_t e;
        int s;
        if (reset) begin
            model_reset();
        end else if (bus.tc) begin
            chain  = {chain[NB-2:0], bus.td};
            rdv_m  = 0;
            perr_m = 0;
            for (int i = 0; i < D; i++) mpar[i] = ^chain[i*W +: W];
        end else begin
            rdv_m  = 0;
            perr_m = 0;
            if (bus.rd_en) begin
                s         = int'(bus.rd_sel);
                last_data = chain[s*W +: W];
                rdv_m     = vmask[s];
                perr_m    = (^last_data) != mpar[s];
            end
            if (bus.wr_clr) begin
                vmask = '0; ptr = 0; movf = 0;
            end
            if (bus.en_in) begin
                if (vmask == {D{1'b1}}) movf = 1;
                chain[ptr*W +: W] = bus.data_in;
                mpar[ptr]         = ^bus.data_in;
                vmask[ptr]        = 1'b1;
                ptr               = (ptr + 1) % D;
            end
        end
        e.data  = last_data;
        e.rdv   = rdv_m;
        e.valid = vmask;
        e.full  = (vmask == {D{1'b1}});
        e.ovf   = movf;
        e.tq    = chain[NB-1];
        e.perr  = perr_m;
        exp_q.push_back(e);
    endtask

    // Monitor: every negedge pops one expectation and compares all outputs
    always @(negedge clk) begin : mon
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("data_out", 64'(bus.data_out), 64'(e.data));
            chk("rd_valid", 64'(bus.rd_valid), 64'(e.rdv));
            chk("valid",    64'(bus.valid),    64'(e.valid));
            chk("full",     64'(bus.full),     64'(e.full));
            chk("ovf",      64'(bus.ovf),      64'(e.ovf));
            chk("tq",       64'(bus.tq),       64'(e.tq));
`ifdef PAGE_REG_PARITY_EN
            chk("par_err",  64'(bus.par_err),  64'(e.perr));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        model_apply();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit en, input bit clr, input bit rd, input int sel,
                         input bit [W-1:0] din, input bit t, input bit d);
        bus.en_in   = en;
        bus.wr_clr  = clr;
        bus.rd_en   = rd;
        bus.rd_sel  = 3'(sel);
        bus.data_in = din;
        bus.tc      = t;
        bus.td      = d;
        step();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        model_reset();
        bus.en_in = 0; bus.wr_clr = 0; bus.rd_en = 0; bus.rd_sel = '0;
        bus.data_in = '0; bus.tc = 0; bus.td = 0;
        idle();
        idle();
        reset = 1'b0;

        // Fill 0x11..0x88, then read back 7..0
        for (int i = 0; i < D; i++) drive(1, 0, 0, 0, 8'((i + 1) * 8'h11), 0, 0);
        for (int i = D - 1; i >= 0; i--) drive(0, 0, 1, i, '0, 0, 0);
        idle();

        // Overflow write, then clear merged with a write, then read entry 0
        drive(1, 0, 0, 0, 8'hAB, 0, 0);
        drive(0, 0, 1, 0, '0, 0, 0);
        drive(1, 1, 0, 0, 8'hCD, 0, 0);
        drive(0, 0, 1, 0, '0, 0, 0);

        // Same-cycle read/write of entry 3 returns pre-write data
        drive(1, 0, 0, 0, 8'h12, 0, 0);
        drive(1, 0, 0, 0, 8'h34, 0, 0);
        drive(1, 0, 1, 3, 8'h5A, 0, 0);
        drive(0, 0, 1, 3, '0, 0, 0);

        // Full unload/load with td = 0,1,0,1..., functional strobes must be ignored
        for (int i = 0; i < NB; i++)
            drive(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, D - 1)),
                  8'($urandom), 1, 1'(i % 2));
        for (int i = 0; i < D; i++) drive(0, 0, 1, i, '0, 0, 0);

        // Random functional traffic with occasional scan cycles mixed in
        for (int i = 0; i < 300; i++)
            drive(1'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom),
                  int'($urandom_range(0, D - 1)), 8'($urandom),
                  ($urandom_range(0, 7) == 0), 1'($urandom));

        // Asynchronous reset in the middle of a scan
        drive(0, 0, 1, int'($urandom_range(0, D - 1)), '0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, '0, 1, 1'($urandom));
        reset = 1'b1;
        #1;
        chk("rst_data_out", 64'(bus.data_out), 64'(0));
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
        chk("rst_valid",    64'(bus.valid),    64'(0));
        chk("rst_full",     64'(bus.full),     64'(0));
        chk("rst_ovf",      64'(bus.ovf),      64'(0));
        chk("rst_tq",       64'(bus.tq),       64'(0));
        drive(0, 0, 0, 0, '0, 1, 1);
        reset = 1'b0;
        drive(1, 0, 0, 0, 8'h3C, 0, 0);
        drive(0, 0, 1, 0, '0, 0, 0);
        drive(0, 0, 1, 1, '0, 0, 0);

`ifdef PAGE_REG_PARITY_EN
        begin
            int idx;
            logic [D-1:0] pv;
            idx = ptr;
            drive(1, 0, 0, 0, 8'h07, 0, 0);
            drive(0, 0, 1, idx, '0, 0, 0);
            pv = dut.par;
            force dut.par = pv ^ (D'(1) << idx);
            mpar[idx] = ~mpar[idx];
            drive(0, 0, 1, idx, '0, 0, 0);
            idle();
            release dut.par;
        end
`endif

        idle();
        @(negedge clk);
        #1;
        chk("queue_drain", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
